// File: rtl/fp16_lane_accum.sv
// rtl/fp16_lane_accum.sv - four-lane FP16 accumulator for FP8 vector-multiply results
// Each lane sums its products over a first/last delimited sequence; sum is held on a valid/ready output.
module fp16_lane_accum #(
  parameter int ID_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [63:0]         in_res,
  input  logic [ID_WIDTH-1:0] in_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         out_res,
  output logic [ID_WIDTH-1:0] out_id
);

  function automatic logic [15:0] canon(input logic [15:0] x);
    if (&x[14:10] && |x[9:0]) return 16'h7E00;
    if (x[14:10] == 5'd0 && |x[9:0]) return {x[15], 15'd0};
    return x;
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0]       a, b, t;
    logic [4:0]        d;
    logic [13:0]       sa, sb, n;
    logic [14:0]       s;
    logic [3:0]        lz;
    logic [9:0]        mant;
    logic signed [6:0] e;
    a = canon(x);
    b = canon(y);
    if ((&a[14:10] && |a[9:0]) || (&b[14:10] && |b[9:0])) return 16'h7E00;
    if (&a[14:10] && &b[14:10]) return (a[15] == b[15]) ? a : 16'h7E00;
    if (&a[14:10]) return a;
    if (&b[14:10]) return b;
    // a carries the larger magnitude, so its sign and exponent lead the result
    if (a[14:0] < b[14:0]) begin
      t = a;
      a = b;
      b = t;
    end
    d  = a[14:10] - b[14:10];
    sa = {|a[14:10], a[9:0], 3'b000};
    sb = {|b[14:10], b[9:0], 3'b000} >> d;
    s  = (a[15] == b[15]) ? ({1'b0, sa} + {1'b0, sb}) : ({1'b0, sa} - {1'b0, sb});
    if (s == 15'd0) return 16'h0000;
    if (s[14]) begin
      e    = $signed({2'b00, a[14:10]}) + 7'sd1;
      mant = 10'(s >> 4);
    end else begin
      lz = 4'd0;
      for (int i = 0; i < 14; i++) begin
        if (s[i]) lz = 4'(13 - i);
      end
      n    = s[13:0] << lz;
      e    = $signed({2'b00, a[14:10]}) - $signed({3'b000, lz});
      mant = 10'(n >> 3);
    end
    if (e < 7'sd1) return {a[15], 15'd0};
    if (e > 7'sd30) return {a[15], 5'h1F, 10'd0};
    return {a[15], e[4:0], mant};
  endfunction

  logic [63:0]         acc_q, acc_d;
  logic [63:0]         res_q, res_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                valid_q, valid_d;
  logic [63:0]         nxt;
  logic                accept;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_id    = id_q;

  always_comb begin
    nxt = 64'd0;
    for (int i = 0; i < 4; i++) begin
      nxt[16*i +: 16] = in_first ? canon(in_res[16*i +: 16])
                                 : fadd(acc_q[16*i +: 16], in_res[16*i +: 16]);
    end
  end

  always_comb begin
    acc_d   = acc_q;
    res_d   = res_q;
    id_d    = id_q;
    valid_d = valid_q;
    if (out_ready) valid_d = 1'b0;
    if (accept) begin
      if (in_last) begin
        acc_d   = 64'd0;
        res_d   = nxt;
        id_d    = in_id;
        valid_d = 1'b1;
      end else begin
        acc_d = nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= 64'd0;
      res_q   <= 64'd0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      res_q   <= res_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fp16_lane_accum.sv
// tb/tb_fp16_lane_accum.sv - directed self-checking bench for fp16_lane_accum
module tb_fp16_lane_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [63:0] in_res = 64'd0;
  logic [31:0] in_id = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_res;
  logic [31:0] out_id;

  int errors = 0;
  int checks = 0;

  fp16_lane_accum #(.ID_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_res(in_res), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_id(out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        single;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic f, input logic l, input logic [63:0] r, input logic [31:0] id);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_res   = r;
    in_id    = id;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    // lanes listed lane3..lane0
    vecs[0] = '{1'b0, {16'h3C00, 16'h3C00, 16'h7C00, 16'h7BFF},
                      {16'hBC00, 16'h1000, 16'hFC00, 16'h7BFF},
                      {16'h0000, 16'h3C00, 16'h7E00, 16'h7C00}};
    vecs[1] = '{1'b1, {16'h0001, 16'h7C01, 16'h8001, 16'hC000}, 64'd0,
                      {16'h0000, 16'h7E00, 16'h8000, 16'hC000}};
    vecs[2] = '{1'b0, {16'h7C00, 16'h3C00, 16'hC000, 16'h4000},
                      {16'h3C00, 16'h7E00, 16'h3C00, 16'hBC00},
                      {16'h7C00, 16'h7E00, 16'hBC00, 16'h3C00}};
    vecs[3] = '{1'b0, {16'h8600, 16'h5640, 16'h3555, 16'hFC00},
                      {16'h0400, 16'h5640, 16'h0000, 16'hFC00},
                      {16'h8000, 16'h5A40, 16'h3555, 16'hFC00}};
    vecs[4] = '{1'b0, {16'h3FFF, 16'h3C00, 16'h3C01, 16'h4900},
                      {16'h3C00, 16'h1200, 16'h3C01, 16'hC880},
                      {16'h41FF, 16'h3C00, 16'h4001, 16'h3C00}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_res", out_res, 64'd0);
    chk("reset_out_id", {32'd0, out_id}, 64'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].single) begin
        beat(1'b1, 1'b1, vecs[i].a, 32'(100 + i));
      end else begin
        beat(1'b1, 1'b0, vecs[i].a, 32'd0);
        beat(1'b0, 1'b1, vecs[i].b, 32'(100 + i));
      end
      chk($sformatf("vec%0d_res", i), out_res, vecs[i].exp);
      chk($sformatf("vec%0d_id", i), {32'd0, out_id}, 64'(100 + i));
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
    end

    // reset in the middle of a sequence
    beat(1'b1, 1'b0, {16'h0000, 16'h3800, 16'hC000, 16'h3C00}, 32'd5);
    rst = 1'b1;
    #2;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_res", out_res, 64'd0);
    chk("midrst_out_id", {32'd0, out_id}, 64'd0);
    rst = 1'b0;
    beat(1'b0, 1'b1, {4{16'h3C00}}, 32'd6);
    chk("midrst_after_res", out_res, {4{16'h3C00}});

    // three-beat sum; only the last beat's id is forwarded
    beat(1'b1, 1'b0, {16'h3800, 16'h3800, 16'hC480, 16'h3C00}, 32'd99);
    chk("sum3_valid_b1", {63'd0, out_valid}, 64'd0);
    beat(1'b0, 1'b0, {16'h3800, 16'h3800, 16'h4480, 16'h4000}, 32'd98);
    chk("sum3_valid_b2", {63'd0, out_valid}, 64'd0);
    beat(1'b0, 1'b1, {16'h3800, 16'h3800, 16'h0000, 16'h4200}, 32'd7);
    chk("sum3_res", out_res, {16'h3E00, 16'h3E00, 16'h0000, 16'h4600});
    chk("sum3_id", {32'd0, out_id}, 64'd7);
    chk("sum3_valid", {63'd0, out_valid}, 64'd1);

    // backpressure with a pending middle beat
    beat(1'b1, 1'b1, {4{16'h4400}}, 32'd10);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_res    = {4{16'h3C00}};
    in_id     = 32'd20;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", c), {63'd0, in_ready}, 64'd0);
      chk($sformatf("bp_res%0d", c), out_res, {4{16'h4400}});
      chk($sformatf("bp_id%0d", c), {32'd0, out_id}, 64'd10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("bp_cleared", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b0;
    beat(1'b0, 1'b1, {4{16'h3C00}}, 32'd11);
    chk("bp_sum_res", out_res, {4{16'h4000}});
    chk("bp_sum_id", {32'd0, out_id}, 64'd11);

    // stall with a pending last beat, which replaces the output on release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_first  = 1'b1;
    in_last   = 1'b1;
    in_res    = {4{16'hC200}};
    in_id     = 32'd12;
    @(posedge clk);
    #1;
    chk("bp2_hold_res", out_res, {4{16'h4000}});
    chk("bp2_hold_id", {32'd0, out_id}, 64'd11);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp2_new_res", out_res, {4{16'hC200}});
    chk("bp2_new_id", {32'd0, out_id}, 64'd12);
    chk("bp2_new_valid", {63'd0, out_valid}, 64'd1);

    // back-to-back single-beat sequences at full throughput
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_res = {4{16'(16'h3C00 + k)}};
      in_id  = 32'(k);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_valid%0d", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("b2b_id%0d", k), {32'd0, out_id}, 64'(k));
      chk($sformatf("b2b_res%0d", k), out_res, {4{16'(16'h3C00 + k)}});
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_drain", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
